box_cmd_sequencer: RTL and testbench
====================================

BOX_CMD_SEQUENCER -- requirements
Module: box_cmd_sequencer

Interface
REQ-001 SHALL have parameter CMD_COUNT, default 8, number of commands per run (legal 1..16).
REQ-002 SHALL have parameter PULSE_CYCLES, default 2, high time of each drawer pulse (legal 1..15).
REQ-003 SHALL have port Clock  in  1  rising-edge clock.
REQ-004 SHALL have port ResetN  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port iStart  in  1  starts one run when sampled high in IDLE.
REQ-006 SHALL have port iDone  in  1  one-cycle completion pulse from the box drawer.
REQ-007 SHALL have port oCmdAddr  out  4  command memory address.
REQ-008 SHALL have port iCmdData  in  18  command word: [17] clear, [16:14] colour, [13:7] x, [6:0] y; valid one cycle after oCmdAddr.
REQ-009 SHALL have port oLoadX  out  1  drawer X-load strobe.
REQ-010 SHALL have port oPlotBox  out  1  drawer plot strobe.
REQ-011 SHALL have port oBlack  out  1  drawer clear-screen strobe.
REQ-012 SHALL have port oXY_Coord  out  7  coordinate to drawer.
REQ-013 SHALL have port oColour  out  3  colour to drawer.
REQ-014 SHALL have port oBusy  out  1  high in every state except IDLE.
REQ-015 SHALL have port oFinished  out  1  one-cycle pulse at run end.
REQ-016 SHALL have port oError  out  1  sticky timeout flag (see Configuration).

Function
REQ-017 SHALL implement states IDLE, FETCH, DECODE, LOADX_HI, LOADX_LO, PLOT_HI, PLOT_LO, BLACK_HI, BLACK_LO, WAIT_DONE, NEXT.
REQ-018 IDLE: iStart=1 -> FETCH, command index cleared to 0; iStart while busy SHALL be ignored.
REQ-019 FETCH: oCmdAddr = index, 1 cycle -> DECODE; DECODE SHALL register iCmdData.
REQ-020 DECODE: clear=1 -> BLACK_HI; else -> LOADX_HI.
REQ-021 LOADX_HI: oLoadX=1, oXY_Coord=x for exactly PULSE_CYCLES cycles -> LOADX_LO.
REQ-022 LOADX_LO: oLoadX=0, oXY_Coord=y, oColour=colour, 1 cycle -> PLOT_HI.
REQ-023 PLOT_HI: oPlotBox=1, oXY_Coord=y, oColour=colour for PULSE_CYCLES cycles -> PLOT_LO (1 cycle, strobe low, y/colour held) -> WAIT_DONE.
REQ-024 BLACK_HI: oBlack=1 for PULSE_CYCLES cycles -> BLACK_LO (1 cycle low) -> WAIT_DONE.
REQ-025 WAIT_DONE: iDone=1 -> NEXT; iDone pulses in any other state SHALL be ignored.
REQ-026 NEXT: index==CMD_COUNT-1 -> IDLE with oFinished=1 for that one transition cycle; else index+1, -> FETCH.
REQ-027 At most one of oLoadX, oPlotBox, oBlack SHALL be high in any cycle; all strobes registered, glitch-free.
REQ-028 Pulse counter 4-bit, index 4-bit; no wrap beyond CMD_COUNT-1.
REQ-029 oXY_Coord and oColour SHALL hold last driven value outside listed states.

Reset
REQ-030 ResetN=0 at any edge, including mid-run, SHALL force IDLE, index=0, pulse counter=0, oCmdAddr=0, all strobes=0, oXY_Coord=0, oColour=0, oBusy=0, oFinished=0, oError=0.
REQ-031 Reset SHALL take priority over iStart and iDone in the same cycle.

Configuration
REQ-032 Macro SEQ_TIMEOUT_EN defined: 15-bit counter runs in WAIT_DONE; reaching 32767 cycles without iDone SHALL set oError=1 (sticky until reset), -> IDLE, no oFinished pulse.
REQ-033 SEQ_TIMEOUT_EN undefined: WAIT_DONE waits indefinitely; oError tied 0.

Verification
REQ-034 Reset, CMD_COUNT=1, cmd0={0,3'd5,7'd10,7'd20}, iStart -> oLoadX high 2 cycles with XY=10, then oPlotBox high 2 cycles with XY=20, colour=5; iDone -> oFinished one pulse, oBusy=0.
REQ-035 cmd0 clear=1 -> only oBlack high 2 cycles, no oLoadX/oPlotBox; iDone -> run ends.
REQ-036 CMD_COUNT=3, iDone returned 5 cycles after each PLOT_LO -> oCmdAddr sequence 0,1,2, single oFinished after third iDone.
REQ-037 iDone pulsed during LOADX_HI and iStart pulsed mid-run -> both ignored; sequence unchanged.
REQ-038 ResetN low during PLOT_HI -> next cycle all strobes 0, oBusy=0; new iStart restarts at address 0.
REQ-039 SEQ_TIMEOUT_EN defined, iDone withheld -> oError=1 at 32767 cycles in WAIT_DONE, oBusy=0, oFinished never asserted.

Source files
------------

// File: rtl/box_cmd_sequencer.sv
// Walks a command memory and drives the box drawer's load/plot/clear strobes.
// Define SEQ_TIMEOUT_EN to abort a run (sticky oError) when iDone never arrives.
module box_cmd_sequencer #(
    parameter int CMD_COUNT    = 8,
    parameter int PULSE_CYCLES = 2
) (
    input  logic        Clock,
    input  logic        ResetN,
    input  logic        iStart,
    input  logic        iDone,
    output logic [3:0]  oCmdAddr,
    input  logic [17:0] iCmdData,
    output logic        oLoadX,
    output logic        oPlotBox,
    output logic        oBlack,
    output logic [6:0]  oXY_Coord,
    output logic [2:0]  oColour,
    output logic        oBusy,
    output logic        oFinished,
    output logic        oError
);

    localparam logic [3:0] IDLE      = 4'd0;
    localparam logic [3:0] FETCH     = 4'd1;
    localparam logic [3:0] DECODE    = 4'd2;
    localparam logic [3:0] LOADX_HI  = 4'd3;
    localparam logic [3:0] LOADX_LO  = 4'd4;
    localparam logic [3:0] PLOT_HI   = 4'd5;
    localparam logic [3:0] PLOT_LO   = 4'd6;
    localparam logic [3:0] BLACK_HI  = 4'd7;
    localparam logic [3:0] BLACK_LO  = 4'd8;
    localparam logic [3:0] WAIT_DONE = 4'd9;
    localparam logic [3:0] NEXT      = 4'd10;

    localparam logic [3:0] LAST_IDX   = 4'(CMD_COUNT - 1);
    localparam logic [3:0] PULSE_LAST = 4'(PULSE_CYCLES - 1);

    logic [3:0]  state;
    logic [3:0]  nstate;
    logic [3:0]  idx;
    logic [3:0]  pcnt;
    logic [17:0] cmd;
    logic [17:0] cur;
    logic        last;
    logic        pdone;
    logic        in_hi;
    logic        tout;

    // The word is only on iCmdData during DECODE; later states use the copy.
    assign cur   = (state == DECODE) ? iCmdData : cmd;
    assign last  = (idx == LAST_IDX);
    assign pdone = (pcnt == PULSE_LAST);
    assign in_hi = (state == LOADX_HI) || (state == PLOT_HI) ||
                   (state == BLACK_HI);

`ifdef SEQ_TIMEOUT_EN
    logic [14:0] tcnt;

    assign tout = (state == WAIT_DONE) && !iDone && (tcnt == 15'd32766);

    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            tcnt   <= '0;
            oError <= 1'b0;
        end else begin
            if ((state == WAIT_DONE) && (nstate == WAIT_DONE))
                tcnt <= tcnt + 15'd1;
            else
                tcnt <= '0;
            if (tout)
                oError <= 1'b1;
        end
    end
`else
    assign tout   = 1'b0;
    assign oError = 1'b0;
`endif

    always_comb begin
        nstate = state;
        unique case (state)
            IDLE:      if (iStart) nstate = FETCH;
            FETCH:     nstate = DECODE;
            DECODE:    nstate = cur[17] ? BLACK_HI : LOADX_HI;
            LOADX_HI:  if (pdone) nstate = LOADX_LO;
            LOADX_LO:  nstate = PLOT_HI;
            PLOT_HI:   if (pdone) nstate = PLOT_LO;
            PLOT_LO:   nstate = WAIT_DONE;
            BLACK_HI:  if (pdone) nstate = BLACK_LO;
            BLACK_LO:  nstate = WAIT_DONE;
            WAIT_DONE: begin
                if (iDone)
                    nstate = NEXT;
                else if (tout)
                    nstate = IDLE;
            end
            NEXT:      nstate = last ? IDLE : FETCH;
            default:   nstate = IDLE;
        endcase
    end

    // Outputs are registered from nstate so they line up with the state.
    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            state     <= IDLE;
            idx       <= '0;
            pcnt      <= '0;
            cmd       <= '0;
            oCmdAddr  <= '0;
            oLoadX    <= 1'b0;
            oPlotBox  <= 1'b0;
            oBlack    <= 1'b0;
            oXY_Coord <= '0;
            oColour   <= '0;
            oBusy     <= 1'b0;
            oFinished <= 1'b0;
        end else begin
            state     <= nstate;
            oLoadX    <= (nstate == LOADX_HI);
            oPlotBox  <= (nstate == PLOT_HI);
            oBlack    <= (nstate == BLACK_HI);
            oBusy     <= (nstate != IDLE);
            oFinished <= (state == NEXT) && last;
            if (in_hi && (nstate == state))
                pcnt <= pcnt + 4'd1;
            else
                pcnt <= '0;
            if ((state == IDLE) && iStart) begin
                idx      <= '0;
                oCmdAddr <= '0;
            end
            if ((state == NEXT) && !last) begin
                idx      <= idx + 4'd1;
                oCmdAddr <= idx + 4'd1;
            end
            if (state == DECODE)
                cmd <= iCmdData;
            case (nstate)
                LOADX_HI: oXY_Coord <= cur[13:7];
                LOADX_LO, PLOT_HI, PLOT_LO: begin
                    oXY_Coord <= cur[6:0];
                    oColour   <= cur[16:14];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_box_cmd_sequencer.sv
// Randomised scoreboard bench for box_cmd_sequencer.
// Drawer events are predicted per command and matched as strobes appear.
module tb_box_cmd_sequencer;

    localparam int N = 3;
    localparam int P = 2;

    logic        Clock = 1'b0;
    logic        ResetN = 1'b0;
    logic        iStart = 1'b0;
    logic        iDone = 1'b0;
    logic [3:0]  oCmdAddr;
    logic [17:0] iCmdData;
    logic        oLoadX;
    logic        oPlotBox;
    logic        oBlack;
    logic [6:0]  oXY_Coord;
    logic [2:0]  oColour;
    logic        oBusy;
    logic        oFinished;
    logic        oError;

    box_cmd_sequencer #(.CMD_COUNT(N), .PULSE_CYCLES(P)) dut (
        .Clock(Clock), .ResetN(ResetN), .iStart(iStart), .iDone(iDone),
        .oCmdAddr(oCmdAddr), .iCmdData(iCmdData), .oLoadX(oLoadX),
        .oPlotBox(oPlotBox), .oBlack(oBlack), .oXY_Coord(oXY_Coord),
        .oColour(oColour), .oBusy(oBusy), .oFinished(oFinished),
        .oError(oError)
    );

    always #5 Clock = ~Clock;

    logic [17:0] mem [16];
    always @(posedge Clock) iCmdData <= mem[oCmdAddr];

    // kind: 0 load-x, 1 plot, 2 clear, 3 finished
    typedef struct {
        int kind;
        int xy;
        int col;
        int addr;
    } ev_t;

    ev_t exp_q[$];
    int  total = 0;
    int  bad = 0;
    int  fin_cnt = 0;
    bit  mon_en = 0;
    bit  resp_en = 0;
    bit  noise = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic pop_check(input int k);
        ev_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event actual=%0d required=none", k);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", k, e.kind);
            if (k == 0) begin
                chk("loadx_xy", oXY_Coord, e.xy);
                chk("loadx_addr", oCmdAddr, e.addr);
            end else if (k == 1) begin
                chk("plot_xy", oXY_Coord, e.xy);
                chk("plot_colour", oColour, e.col);
            end else if (k == 2) begin
                chk("black_addr", oCmdAddr, e.addr);
            end
        end
    endtask

    logic [2:0] prev = '0;
    int         w [3];
    logic       fin_prev = 1'b0;

    // Monitor: pops one expected event per strobe or finish pulse.
    always @(negedge Clock) begin
        logic [2:0] s;
        s = {oBlack, oPlotBox, oLoadX};
        if (!mon_en) begin
            prev     = '0;
            fin_prev = 1'b0;
            for (int k = 0; k < 3; k++) w[k] = 0;
        end else begin
            if (s != 3'b000)
                chk("strobe_onehot", 32'($countones(s)), 1);
            for (int k = 0; k < 3; k++) begin
                if (s[k] && !prev[k]) begin
                    w[k] = 1;
                    pop_check(k);
                end else if (s[k]) begin
                    w[k]++;
                end else if (prev[k]) begin
                    chk("pulse_width", w[k], P);
                end
            end
            if (fin_prev)
                chk("finished_one_cycle", oFinished, 0);
            if (oFinished) begin
                pop_check(3);
                chk("finished_busy", oBusy, 0);
                fin_cnt++;
            end
            prev     = s;
            fin_prev = oFinished;
        end
    end

    int         dcnt = 0;
    logic [1:0] pe = '0;

    // Drawer model: iDone 1..6 cycles after a plot/clear pulse ends.
    always @(negedge Clock) begin
        if (!resp_en) begin
            dcnt  = 0;
            iDone = 1'b0;
        end else begin
            iDone = 1'b0;
            if (dcnt > 0) begin
                dcnt--;
                if (dcnt == 0) iDone = 1'b1;
            end
            if ((pe[0] && !oPlotBox) || (pe[1] && !oBlack))
                dcnt = $urandom_range(1, 6);
            if (noise && oLoadX && ($urandom_range(0, 2) == 0))
                iDone = 1'b1;
        end
        pe = {oBlack, oPlotBox};
    end

    task automatic fill_random();
        logic [17:0] v;
        for (int i = 0; i < N; i++) begin
            v = 18'($urandom);
            v[17] = ($urandom_range(0, 2) == 0);
            mem[i] = v;
        end
    endtask

    task automatic push_model();
        for (int i = 0; i < N; i++) begin
            if (mem[i][17]) begin
                exp_q.push_back('{2, 0, 0, i});
            end else begin
                exp_q.push_back('{0, int'(mem[i][13:7]), 0, i});
                exp_q.push_back('{1, int'(mem[i][6:0]),
                                  int'(mem[i][16:14]), i});
            end
        end
        exp_q.push_back('{3, 0, 0, 0});
    endtask

    task automatic pulse_start();
        @(negedge Clock);
        iStart = 1'b1;
        @(negedge Clock);
        iStart = 1'b0;
    endtask

    task automatic run_once(input bit nz);
        int f0;
        bit ok;
        f0 = fin_cnt;
        ok = 0;
        noise = nz;
        push_model();
        pulse_start();
        for (int c = 0; c < 600; c++) begin
            @(negedge Clock);
            iStart = nz && oBusy && ($urandom_range(0, 4) == 0);
            if (fin_cnt != f0) begin
                ok = 1;
                break;
            end
        end
        iStart = 1'b0;
        noise = 0;
        chk("run_finished", ok, 1);
        chk("finish_count", fin_cnt - f0, ok ? 1 : 0);
        chk("queue_empty", exp_q.size(), 0);
        chk("error_low", oError, 0);
        exp_q.delete();
        repeat (3) @(negedge Clock);
        chk("finish_count_after", fin_cnt - f0, ok ? 1 : 0);
    endtask

    task automatic reset_checks(input string p);
        chk({p, "_loadx"}, oLoadX, 0);
        chk({p, "_plot"}, oPlotBox, 0);
        chk({p, "_black"}, oBlack, 0);
        chk({p, "_busy"}, oBusy, 0);
        chk({p, "_finished"}, oFinished, 0);
        chk({p, "_addr"}, oCmdAddr, 0);
        chk({p, "_xy"}, oXY_Coord, 0);
        chk({p, "_colour"}, oColour, 0);
        chk({p, "_error"}, oError, 0);
    endtask

    initial begin
        bit seen;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        ResetN = 1'b0;
        repeat (3) @(negedge Clock);
        reset_checks("reset");
        ResetN = 1'b1;
        mon_en = 1;
        resp_en = 1;

        mem[0] = {1'b0, 3'd5, 7'd10, 7'd20};
        mem[1] = {1'b1, 3'd0, 7'd0, 7'd0};
        mem[2] = {1'b0, 3'd7, 7'd127, 7'd0};
        run_once(0);

        for (int r = 0; r < 8; r++) begin
            fill_random();
            run_once(r[0]);
        end

        fill_random();
        mem[0][17] = 1'b0;
        push_model();
        pulse_start();
        seen = 0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge Clock);
            seen = oPlotBox;
        end
        chk("reached_plot", seen, 1);
        mon_en = 0;
        resp_en = 0;
        ResetN = 1'b0;
        @(negedge Clock);
        reset_checks("midrun_reset");
        ResetN = 1'b1;
        exp_q.delete();
        @(negedge Clock);
        mon_en = 1;
        resp_en = 1;
        fill_random();
        run_once(0);

`ifdef SEQ_TIMEOUT_EN
        begin
            int cyc;
            bit fin_seen;
            mon_en = 0;
            resp_en = 0;
            mem[0] = {1'b0, 3'd2, 7'd3, 7'd4};
            pulse_start();
            seen = 0;
            for (int c = 0; c < 100 && !seen; c++) begin
                @(negedge Clock);
                seen = oPlotBox;
            end
            for (int c = 0; c < 100 && oPlotBox; c++) @(negedge Clock);
            cyc = 0;
            fin_seen = 0;
            while (oBusy && cyc < 33000) begin
                @(negedge Clock);
                cyc++;
                fin_seen |= oFinished;
            end
            chk("timeout_cycles", cyc, 32768);
            chk("timeout_error", oError, 1);
            chk("timeout_busy", oBusy, 0);
            chk("timeout_no_finish", fin_seen, 0);
            repeat (4) @(negedge Clock);
            chk("timeout_sticky", oError, 1);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
